word_scan_ctrl: RTL
===================

# word_scan_ctrl

Bit-serial scan controller for the 1101 sequence detector. It accepts parallel words over a valid/ready handshake and shifts each word MSB-first through an internal overlapping 1101 detector. It reports every match as a one-cycle pulse and returns a per-word match count with a done strobe. It sits between a word-oriented producer and the detection logic, and owns the sequencing and the history policy.

## Interface

Parameters:
- WIDTH, default 8: bits per word, ≥ 4.
- CW, default 4: match counter width; the counter saturates.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset, asynchronous, active-low.
- in_valid, input, 1: producer offers in_data.
- in_data, input, WIDTH: word to scan; bit WIDTH-1 is scanned first.
- in_carry, input, 1: sampled at accept. 1 keeps detector history from the previous word; 0 clears it to D0.
- in_ready, output, 1: controller can accept a word.
- det_pulse, output, 1: one-cycle pulse per detected 1101.
- match_count, output, CW: matches in the current or last word.
- done, output, 1: one-cycle strobe; match_count is final.
- busy, output, 1: high in SHIFT or DONE.

## Operation

Control FSM, states IDLE, SHIFT and DONE:
- IDLE:
  - in_ready=1.
  - On in_valid=1, the word is accepted at that edge:
    - load the shift register with in_data;
    - bit counter = 0;
    - match_count = 0;
    - detector state = D0 if in_carry=0, otherwise unchanged;
    - go to SHIFT.
- SHIFT:
  - in_ready=0; in_valid and in_data are ignored.
  - Each cycle consumes shreg[WIDTH-1] into the detector, shifts left by 1 and increments the bit counter.
  - After the cycle that consumes bit index WIDTH-1, go to DONE.
- DONE:
  - done=1 for exactly one cycle, then go to IDLE.
  - No word is accepted in DONE.

Detector (overlapping), states D0, D1, D11, D110. The detector advances only in SHIFT:
- D0: 1→D1, 0→D0.
- D1: 1→D11, 0→D0.
- D11: 1→D11, 0→D110.
- D110: 1→D1 with match, 0→D0.
- The detector state holds in IDLE and DONE, so history is available to the next word when in_carry=1.

Match accounting:
- A match registers det_pulse=1 at the next edge.
- match_count increments at that same edge and saturates at 2^CW-1.
- match_count holds its value after DONE until the next accept clears it.

Reset, asynchronous, may arrive mid-operation:
- FSM = IDLE, detector = D0, shreg = 0, bit counter = 0.
- match_count = 0, det_pulse = 0, done = 0, busy = 0, in_ready = 1.
- An in-flight word is discarded; there is no partial done.

## Timing

- An accept edge at the end of cycle 0 puts the controller in SHIFT for cycles 1..WIDTH. Cycle j consumes bit index j-1.
- A match completed by bit k (consumed in cycle k+1) gives det_pulse in cycle k+2.
  - A match on the last bit gives det_pulse in the DONE cycle WIDTH+1, and match_count already includes it.
- done is high in cycle WIDTH+1, and in_ready is high again in cycle WIDTH+2.
- Throughput is one word per WIDTH+2 cycles. The earliest next accept is at the end of cycle WIDTH+2.
- det_pulse never lasts more than one cycle per match. Back-to-back pulses are impossible because a match needs at least 3 bits after an overlap.
- Outputs are registered except in_ready and busy, which decode the FSM state.

## Test plan

- Reset, then 8'b1101_1010 with in_carry=0, accepted at cycle 0:
  - det_pulse in cycles 5 and 8;
  - done in cycle 9 with match_count=2;
  - in_ready=1 in cycle 10.
- 8'b1101_1011 → det_pulse in cycles 5 and 8; match_count=2 at done. 8'hFF and 8'h00 → no det_pulse and match_count=0.
- Carry, first word 8'b0000_0110, then 8'b1000_0000:
  - second word with in_carry=1 → det_pulse in cycle 2 of that word and match_count=1;
  - repeat with in_carry=0 → match_count=0.
- Handshake: hold in_valid=1 with changing in_data through SHIFT and DONE → in_ready=0, the data is ignored, and exactly one word is scanned per accept.
- Saturation, CW=2 with WIDTH=16 and 16'b1101_1011_0110_1101:
  - the overlapping chain completes 5 matches;
  - match_count stays at 3 and det_pulse still fires 5 times.
- Reset asserted in cycle 4 of SHIFT:
  - all outputs return to reset values immediately, with in_ready=1 and no done;
  - a following 8'b1101_0000 with in_carry=1 gives match_count=1.

Source files
------------

// File: rtl/word_scan_ctrl.sv
// rtl/word_scan_ctrl.sv - word-to-bit-serial scan controller around an overlapping 1101 detector
module word_scan_ctrl #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_carry,
    output logic             in_ready,
    output logic             det_pulse,
    output logic [CW-1:0]    match_count,
    output logic             done,
    output logic             busy
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
    localparam logic [CW-1:0] COUNT_MAX = {CW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        D0,
        D1,
        D11,
        D110
    } det_t;

    state_t           state_q, state_d;
    det_t             det_q, det_d;
    det_t             det_step;
    logic             det_hit;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bitcnt_q, bitcnt_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pulse_q, pulse_d;
    logic             done_q, done_d;
    logic             bit_in;

    assign bit_in      = shreg_q[WIDTH-1];
    assign in_ready    = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign det_pulse   = pulse_q;
    assign match_count = count_q;
    assign done        = done_q;

    // Detector transition for the bit currently at the head of the shift register
    always_comb begin
        det_step = D0;
        det_hit  = 1'b0;
        case (det_q)
            D0:   det_step = bit_in ? D1  : D0;
            D1:   det_step = bit_in ? D11 : D0;
            D11:  det_step = bit_in ? D11 : D110;
            D110: begin
                if (bit_in) begin
                    det_step = D1;
                    det_hit  = 1'b1;
                end else begin
                    det_step = D0;
                end
            end
            default: det_step = D0;
        endcase
    end

    // Control FSM: accept in IDLE, scan MSB-first in SHIFT, strobe done in DONE
    always_comb begin
        state_d  = state_q;
        det_d    = det_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        count_d  = count_q;
        pulse_d  = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    shreg_d  = in_data;
                    bitcnt_d = '0;
                    count_d  = '0;
                    if (!in_carry) begin
                        det_d = D0;
                    end
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                det_d    = det_step;
                shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
                bitcnt_d = bitcnt_q + 1'b1;
                if (det_hit) begin
                    pulse_d = 1'b1;
                    if (count_q != COUNT_MAX) begin
                        count_d = count_q + 1'b1;
                    end
                end
                if (bitcnt_q == LAST_BIT) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset discards any word in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            det_q    <= D0;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            count_q  <= '0;
            pulse_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            det_q    <= det_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            count_q  <= count_d;
            pulse_q  <= pulse_d;
            done_q   <= done_d;
        end
    end

endmodule
